kernel_two_mm: RTL and testbench

KERNEL_TWO_MM -- requirements
Module: kernel_2mm

---
 rtl/kernel_two_mm.sv | 183 ++++++++++++++++++
 tb/tb_kernel_two_mm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_two_mm.sv
// kernel_two_mm: PolyBench 2mm (tmp = alpha*A*B, D = tmp*C + beta*D) over one dual-port word memory
module kernel_two_mm #(
    parameter int ADDR_WID = 13,
    parameter int DATA_WID = 32,
    parameter int N = 16
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    output logic [ADDR_WID-1:0] indata_address0,
    output logic [ADDR_WID-1:0] indata_address1,
    output logic                indata_ce0,
    output logic                indata_we0,
    output logic                indata_ce1,
    output logic                indata_we1,
    output logic [DATA_WID-1:0] indata_d0,
    output logic [DATA_WID-1:0] indata_d1,
    input  logic [DATA_WID-1:0] indata_q0,
    input  logic [DATA_WID-1:0] indata_q1
);
    localparam int IW = $clog2(N);
    localparam logic [ADDR_WID-1:0] A_BASE = ADDR_WID'(256);
    localparam logic [ADDR_WID-1:0] B_BASE = ADDR_WID'(512);
    localparam logic [ADDR_WID-1:0] C_BASE = ADDR_WID'(768);
    localparam logic [ADDR_WID-1:0] D_BASE = ADDR_WID'(1024);
    localparam logic [ADDR_WID-1:0] T_BASE = ADDR_WID'(1280);

    typedef enum logic [3:0] {
        IDLE, PAR_RD, PAR_CAP, P1_RD, P1_CAP, P1_WR,
        P2_DRD, P2_DCAP, P2_RD, P2_CAP, P2_WR, DONE
    } state_t;

    state_t state_q, state_d;
    logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DATA_WID-1:0] acc_q, acc_d, alpha_q, alpha_d, beta_q, beta_d;
    logic k_last, j_last, i_last, ij_last;
    logic [ADDR_WID-1:0] row_i, row_k, off_ik, off_ij, off_kj;

    assign k_last  = k_q == IW'(N - 1);
    assign j_last  = j_q == IW'(N - 1);
    assign i_last  = i_q == IW'(N - 1);
    assign ij_last = i_last && j_last;
    assign row_i   = ADDR_WID'(i_q) * ADDR_WID'(N);
    assign row_k   = ADDR_WID'(k_q) * ADDR_WID'(N);
    assign off_ik  = row_i + ADDR_WID'(k_q);
    assign off_ij  = row_i + ADDR_WID'(j_q);
    assign off_kj  = row_k + ADDR_WID'(j_q);

    assign ap_done    = state_q == DONE;
    assign ap_ready   = state_q == DONE;
    assign ap_idle    = state_q == IDLE;
    assign indata_we0 = 1'b0;
    assign indata_d0  = '0;

    // state register; reset drops straight back to IDLE and aborts any access
    always_ff @(posedge ap_clk) begin
        state_q <= !ap_rst ? IDLE : state_d;
    end

    // datapath registers: loop indices, accumulator and the two scalars
    always_ff @(posedge ap_clk) begin
        if (!ap_rst) begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            alpha_q <= '0;
            beta_q  <= '0;
        end else begin
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            alpha_q <= alpha_d;
            beta_q  <= beta_d;
        end
    end

    // next state: each element is a k-loop of read/capture pairs followed by one write
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ap_start ? PAR_RD : IDLE;
            PAR_RD:  state_d = PAR_CAP;
            PAR_CAP: state_d = P1_RD;
            P1_RD:   state_d = P1_CAP;
            P1_CAP:  state_d = k_last ? P1_WR : P1_RD;
            P1_WR:   state_d = ij_last ? P2_DRD : P1_RD;
            P2_DRD:  state_d = P2_DCAP;
            P2_DCAP: state_d = P2_RD;
            P2_RD:   state_d = P2_CAP;
            P2_CAP:  state_d = k_last ? P2_WR : P2_RD;
            P2_WR:   state_d = ij_last ? DONE : P2_DRD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // datapath update: capture states consume read data, write states step (i,j) row-major
    always_comb begin
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        alpha_d = alpha_q;
        beta_d  = beta_q;
        case (state_q)
            PAR_CAP: begin
                alpha_d = indata_q0;
                beta_d  = indata_q1;
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                acc_d   = '0;
            end
            P1_CAP: begin
                acc_d = acc_q + alpha_q * indata_q0 * indata_q1;
                k_d   = k_last ? k_q : k_q + 1'b1;
            end
            P2_DCAP: acc_d = beta_q * indata_q0;
            P2_CAP: begin
                acc_d = acc_q + indata_q0 * indata_q1;
                k_d   = k_last ? k_q : k_q + 1'b1;
            end
            P1_WR, P2_WR: begin
                acc_d = '0;
                k_d   = '0;
                j_d   = j_last ? '0 : j_q + 1'b1;
                i_d   = j_last ? (i_last ? '0 : i_q + 1'b1) : i_q;
            end
            default: ;
        endcase
    end

    // memory port drive; addresses are parked at zero whenever their port is idle
    always_comb begin
        indata_ce0      = 1'b0;
        indata_ce1      = 1'b0;
        indata_we1      = 1'b0;
        indata_address0 = '0;
        indata_address1 = '0;
        indata_d1       = '0;
        case (state_q)
            PAR_RD: begin
                indata_ce0      = 1'b1;
                indata_ce1      = 1'b1;
                indata_address1 = ADDR_WID'(1);
            end
            P1_RD: begin
                indata_ce0      = 1'b1;
                indata_address0 = A_BASE + off_ik;
                indata_ce1      = 1'b1;
                indata_address1 = B_BASE + off_kj;
            end
            P1_WR: begin
                indata_ce1      = 1'b1;
                indata_we1      = 1'b1;
                indata_address1 = T_BASE + off_ij;
                indata_d1       = acc_q;
            end
            P2_DRD: begin
                indata_ce0      = 1'b1;
                indata_address0 = D_BASE + off_ij;
            end
            P2_RD: begin
                indata_ce0      = 1'b1;
                indata_address0 = T_BASE + off_ik;
                indata_ce1      = 1'b1;
                indata_address1 = C_BASE + off_kj;
            end
            P2_WR: begin
                indata_ce1      = 1'b1;
                indata_we1      = 1'b1;
                indata_address1 = D_BASE + off_ij;
                indata_d1       = acc_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_kernel_two_mm.sv
// tb_kernel_two_mm: directed bench for kernel_two_mm with a memory model and a matrix-level reference
module tb_kernel_two_mm;
    logic        ap_clk = 1'b0;
    logic        ap_rst, ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [12:0] indata_address0, indata_address1;
    logic        indata_ce0, indata_we0, indata_ce1, indata_we1;
    logic [31:0] indata_d0, indata_d1, indata_q0, indata_q1;

    logic [31:0] mem     [8192];
    logic [31:0] img     [8192];
    logic [31:0] w       [8192];
    logic [31:0] exp_mem [8192];
    logic [31:0] exp2    [8192];
    logic        load   = 1'b0;
    logic        mon_en = 1'b0;
    int          total = 0, bad = 0, done_cnt = 0;

    kernel_two_mm dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .indata_address0(indata_address0), .indata_address1(indata_address1),
        .indata_ce0(indata_ce0), .indata_we0(indata_we0),
        .indata_ce1(indata_ce1), .indata_we1(indata_we1),
        .indata_d0(indata_d0), .indata_d1(indata_d1),
        .indata_q0(indata_q0), .indata_q1(indata_q1)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // external memory: one-cycle read latency, port 1 writes; bulk image load while idle
    always @(posedge ap_clk) begin
        if (load) begin
            for (int a = 0; a < 8192; a++) mem[a] <= img[a];
        end else begin
            if (indata_ce0) indata_q0 <= mem[indata_address0];
            if (indata_ce1) begin
                if (indata_we1) mem[indata_address1] <= indata_d1;
                else indata_q1 <= mem[indata_address1];
            end
        end
    end

    // per-cycle protocol checks and write-data checks against the reference image
    always @(negedge ap_clk) begin
        if (mon_en) begin
            if (ap_done) done_cnt++;
            chk("we0 low", 32'(indata_we0), 0);
            chk("d0 zero", indata_d0, 0);
            chk("ready equals done", 32'(ap_ready), 32'(ap_done));
            if (ap_idle || ap_done) chk("strobes low idle/done", 32'({indata_ce0, indata_ce1, indata_we1}), 0);
            if (!indata_ce0) chk("addr0 parked", 32'(indata_address0), 0);
            if (!indata_ce1) chk("addr1 parked", 32'({indata_we1, indata_address1}), 0);
            if (indata_ce1 && indata_we1) begin
                chk("write region", 32'(indata_address1 >= 13'd1024 && indata_address1 < 13'd1536), 1);
                chk($sformatf("write data @%0d", indata_address1), indata_d1, exp_mem[indata_address1]);
            end
        end
    end

    // reference: tmp = alpha*A*B then D = tmp*C + beta*D, modulo 2^32, applied to w in place
    task automatic step_2mm();
        logic [31:0] al, be, s;
        al = w[0];
        be = w[1];
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                s = 0;
                for (int k = 0; k < 16; k++) s = s + al * w[256 + r*16 + k] * w[512 + k*16 + c];
                w[1280 + r*16 + c] = s;
            end
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                s = be * w[1024 + r*16 + c];
                for (int k = 0; k < 16; k++) s = s + w[1280 + r*16 + k] * w[768 + k*16 + c];
                w[1024 + r*16 + c] = s;
            end
    endtask

    task automatic fill_garbage();
        for (int a = 0; a < 8192; a++) img[a] = 32'h5555_0000 + 32'(a);
    endtask

    task automatic load_mem();
        @(negedge ap_clk) load = 1'b1;
        @(negedge ap_clk) load = 1'b0;
        for (int a = 0; a < 8192; a++) w[a] = img[a];
        step_2mm();
        for (int a = 0; a < 8192; a++) exp_mem[a] = w[a];
    endtask

    // start the kernel; return at the DONE cycle or at cycle stop_at, whichever first
    task automatic go(input int stop_at, input bit hold, output int cyc);
        ap_start = 1'b1;
        cyc = 0;
        for (int n = 1; n <= 20000; n++) begin
            @(negedge ap_clk);
            cyc = n;
            if (ap_done || n == stop_at) break;
        end
        if (!hold) ap_start = 1'b0;
    endtask

    task automatic check_regions(input string tag);
        for (int a = 1024; a < 1536; a++) chk($sformatf("%s mem[%0d]", tag, a), mem[a], exp_mem[a]);
    endtask

    task automatic reset_pulse(input string tag);
        ap_rst = 1'b0;
        ap_start = 1'b0;
        @(negedge ap_clk);
        chk({tag, " idle after reset"}, 32'(ap_idle), 1);
        chk({tag, " ce after reset"}, 32'({indata_ce0, indata_ce1}), 0);
        chk({tag, " done after reset"}, 32'(ap_done), 0);
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b1;
        repeat (3) @(negedge ap_clk);
        chk({tag, " still idle"}, 32'(ap_idle), 1);
    endtask

    initial begin
        int cyc, d0;
        ap_rst = 1'b0;
        ap_start = 1'b1;
        repeat (3) begin
            @(negedge ap_clk);
            chk("reset idle", 32'(ap_idle), 1);
            chk("reset strobes", 32'({indata_ce0, indata_we0, indata_ce1, indata_we1}), 0);
            chk("reset done", 32'({ap_done, ap_ready}), 0);
            chk("reset addr/data", 32'(indata_address0 | indata_address1) | indata_d1, 0);
        end
        mon_en = 1'b1;
        ap_start = 1'b0;
        ap_rst = 1'b1;

        // identity A,B with C=M: abort in phase 2, then a clean rerun
        fill_garbage();
        img[0] = 1;
        img[1] = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                img[256 + r*16 + c] = 32'(r == c);
                img[512 + r*16 + c] = 32'(r == c);
                img[768 + r*16 + c] = 32'(r*16 + c);
            end
        load_mem();
        chk("model tmp[2][2]", exp_mem[1280 + 34], 1);
        chk("model D[3][5]", exp_mem[1024 + 53], 53);
        d0 = done_cnt;
        go(8600, 1'b0, cyc);
        chk("abort point reached", 32'(cyc), 8600);
        reset_pulse("abort");
        chk("abort no done", 32'(done_cnt - d0), 0);
        chk("partial D[0][3]", mem[1027], 3);
        chk("untouched D[0][4]", mem[1028], 32'h5555_0404);
        go(0, 1'b0, cyc);
        chk("identity latency", 32'(cyc), 17411);
        check_regions("identity");
        chk("identity D[15][15]", mem[1024 + 255], 255);
        chk("identity tmp[7][7]", mem[1280 + 119], 1);
        chk("identity tmp[7][8]", mem[1280 + 120], 0);
        @(negedge ap_clk);

        // all ones with start held high: two back-to-back runs, second aborted in phase 2
        fill_garbage();
        img[0] = 2;
        img[1] = 3;
        for (int a = 256; a < 1280; a++) img[a] = 1;
        load_mem();
        step_2mm();
        for (int a = 0; a < 8192; a++) exp2[a] = w[a];
        chk("model tmp ones", exp_mem[1280], 32);
        chk("model D ones", exp_mem[1024], 515);
        chk("model D second run", exp2[1024], 2057);
        d0 = done_cnt;
        go(0, 1'b1, cyc);
        chk("ones latency", 32'(cyc), 17411);
        check_regions("ones");
        chk("ones tmp[6][4]", mem[1280 + 100], 32);
        chk("ones D[12][8]", mem[1024 + 200], 515);
        for (int a = 0; a < 8192; a++) exp_mem[a] = exp2[a];
        @(negedge ap_clk);
        chk("held start idle gap", 32'(ap_idle), 1);
        chk("held start done pulse", 32'(ap_done), 0);
        chk("single done pulse", 32'(done_cnt - d0), 1);
        @(negedge ap_clk);
        chk("rerun leaves idle", 32'(ap_idle), 0);
        chk("rerun param read", 32'({indata_ce0, indata_ce1, indata_we1}), 32'b110);
        chk("rerun param addrs", 32'({indata_address0, indata_address1}), 1);
        ap_start = 1'b0;
        repeat (8599) @(negedge ap_clk);
        reset_pulse("rerun abort");
        chk("rerun no done", 32'(done_cnt - d0), 1);
        chk("rerun D[0][0]", mem[1024], 2057);
        chk("rerun D[15][15] untouched", mem[1024 + 255], 515);

        // 0x10000 scalars wrap the phase-1 products to zero
        fill_garbage();
        img[0] = 32'h10000;
        img[1] = 1;
        for (int a = 256; a < 768; a++) img[a] = 32'h10000;
        for (int a = 768; a < 1024; a++) img[a] = 0;
        for (int a = 1024; a < 1280; a++) img[a] = 7;
        load_mem();
        chk("model tmp wrap", exp_mem[1280], 0);
        chk("model D wrap", exp_mem[1024], 7);
        go(0, 1'b0, cyc);
        chk("wrap latency", 32'(cyc), 17411);
        check_regions("wrap");
        chk("wrap tmp[1][1]", mem[1280 + 17], 0);
        chk("wrap D[1][1]", mem[1024 + 17], 7);
        repeat (3) @(negedge ap_clk);
        chk("final idle", 32'(ap_idle), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
